// File: rtl/bias_buf_pkg.sv
// Shared definitions for the bias buffer, its loader and the layer controller.
//   BIAS_W       width of one bias (bits)
//   BUFFER_NUM   banks per bias row for the default geometry
//   state_t      loader FSM states {IDLE, LOAD, DONE}
//   calc_buffer_num()  banks per row for an arbitrary geometry
package bias_buf_pkg;

    localparam int unsigned BIAS_W           = 8;
    localparam int unsigned X_PE_DEFAULT     = 16;
    localparam int unsigned DATA_LEN_DEFAULT = 64;

    function automatic int unsigned calc_buffer_num(input int unsigned x_pe,
                                                    input int unsigned data_len);
        return (BIAS_W * x_pe) / data_len;
    endfunction

    localparam int unsigned BUFFER_NUM = calc_buffer_num(X_PE_DEFAULT, DATA_LEN_DEFAULT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bias_loader.sv
// bias_loader: writer side of the bias buffer.
// Accepts a load command (base row, row count) and then a stream of DATA_LEN-bit
// bias beats, steering beat k to bank k%NUM_BANKS of row base + k/NUM_BANKS
// (row address wraps silently). Write port outputs are registered.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   cfg_valid/cfg_ready          load command handshake (cfg_base, cfg_rows)
//   s_valid/s_ready/s_data       bias beat stream
//   data_wr/wr_addr/wr_en        bias buffer write port, wr_en one-hot per bank
//   done                         1-cycle pulse when the load is complete
//   idle                         high while waiting for a command
//   abort                        (only with BIAS_LOADER_ABORT_EN) end the load early
module bias_loader
    import bias_buf_pkg::*;
#(
    parameter  int unsigned X_PE      = 16,
    parameter  int unsigned ADDR_LEN  = 9,
    parameter  int unsigned DATA_LEN  = 64,
    localparam int unsigned NUM_BANKS = calc_buffer_num(X_PE, DATA_LEN)
) (
    input  logic                          clk,
    input  logic                          rst_n,
`ifdef BIAS_LOADER_ABORT_EN
    input  logic                          abort,
`endif
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [ADDR_LEN-1:0]           cfg_base,
    input  logic [ADDR_LEN:0]             cfg_rows,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_LEN-1:0]           s_data,
    output logic [DATA_LEN*NUM_BANKS-1:0] data_wr,
    output logic [ADDR_LEN-1:0]           wr_addr,
    output logic [NUM_BANKS-1:0]          wr_en,
    output logic                          done,
    output logic                          idle
);

    localparam int unsigned         BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [BANK_W-1:0]   LAST_BANK = BANK_W'(NUM_BANKS - 1);
    localparam logic [ADDR_LEN:0]   ROW_ONE   = (ADDR_LEN + 1)'(1);
    localparam logic [ADDR_LEN-1:0] ADDR_ONE  = ADDR_LEN'(1);

    state_t              state_q, state_d;
    logic [ADDR_LEN-1:0] base_q;
    logic [ADDR_LEN:0]   rows_q;
    logic [BANK_W-1:0]   bank_q;
    logic [ADDR_LEN-1:0] row_q;
    logic                cfg_fire;
    logic                s_fire;
    logic                last_beat;
    logic                abort_hit;

`ifdef BIAS_LOADER_ABORT_EN
    assign abort_hit = (state_q == LOAD) && abort;
`else
    assign abort_hit = 1'b0;
`endif

    // Row offset never exceeds rows-1, so the extra top bit only matters for the compare.
    assign last_beat = (bank_q == LAST_BANK) && ({1'b0, row_q} == (rows_q - ROW_ONE));

    always_comb begin
        state_d   = state_q;
        cfg_ready = 1'b0;
        s_ready   = 1'b0;
        done      = 1'b0;
        idle      = 1'b0;
        cfg_fire  = 1'b0;
        s_fire    = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                idle      = 1'b1;
                if (cfg_valid) begin
                    cfg_fire = 1'b1;
                    state_d  = (cfg_rows == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (abort_hit) begin
                    state_d = DONE;
                end else begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        s_fire = 1'b1;
                        if (last_beat) state_d = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            rows_q  <= '0;
            bank_q  <= '0;
            row_q   <= '0;
            wr_en   <= '0;
            wr_addr <= '0;
            data_wr <= '0;
        end else begin
            state_q <= state_d;
            wr_en   <= '0;
            if (cfg_fire) begin
                base_q <= cfg_base;
                rows_q <= cfg_rows;
                bank_q <= '0;
                row_q  <= '0;
            end
            if (s_fire) begin
                // Address arithmetic is ADDR_LEN wide, so rows past the top wrap to 0.
                wr_addr <= base_q + row_q;
                for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                    if (bank_q == BANK_W'(b)) begin
                        wr_en[b]                      <= 1'b1;
                        data_wr[b*DATA_LEN +: DATA_LEN] <= s_data;
                    end
                end
                if (bank_q == LAST_BANK) begin
                    bank_q <= '0;
                    row_q  <= row_q + ADDR_ONE;
                end else begin
                    bank_q <= bank_q + BANK_W'(1);
                end
            end
        end
    end

endmodule
